// File: rtl/fp_mul_host.sv
// Host side of a byte-serial link to a double-precision multiplier: ships A then B
// LSB byte first, waits (bounded) for the READY edge, then collects the 8-byte product.
module fp_mul_host #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [63:0] i_op_a,
  input  logic [63:0] i_op_b,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [63:0] o_result,
  output logic        o_enable,
  output logic [7:0]  o_data_in,
  input  logic [7:0]  i_data_out,
  input  logic        i_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_RECV = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT - 32'd1);

  state_t        r_state;
  state_t        w_next_state;
  logic [15:0]   r_cnt;
  logic [127:0]  r_tx;
  logic [63:0]   r_rx;
  logic          r_ready_q;
  logic          w_rise;
  logic          w_busy_nx;
  logic          w_done_nx;
  logic          w_err_nx;
  logic          w_enable_nx;
  logic [63:0]   w_result_nx;

  assign w_rise    = i_ready & ~r_ready_q;
  // r_tx shifts in zeros, so it is all-zero once the 16 bytes are out
  assign o_data_in = r_tx[7:0];

  // State register and link datapath (shared counter: SEND bytes, WAIT cycles, RECV bytes)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_tx      <= 128'd0;
      r_rx      <= 64'd0;
      r_ready_q <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ready_q <= i_ready;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 16'd0;
          if (i_start) begin
            r_tx <= {i_op_b, i_op_a};
          end else begin
            r_tx <= r_tx;
          end
        end
        S_SEND: begin
          r_tx  <= {8'h00, r_tx[127:8]};
          r_cnt <= (r_cnt == 16'd15) ? 16'd0 : r_cnt + 16'd1;
        end
        S_WAIT: begin
          if (w_rise) begin
            r_rx  <= {i_data_out, r_rx[63:8]};
            r_cnt <= 16'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RECV: begin
          r_rx  <= {i_data_out, r_rx[63:8]};
          r_cnt <= r_cnt + 16'd1;
        end
        default: begin
          r_cnt <= 16'd0;
        end
      endcase
    end
  end

  // Next-state logic; a READY edge beats a same-cycle timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: w_next_state = i_start ? S_SEND : S_IDLE;
      S_SEND: w_next_state = (r_cnt == 16'd15) ? S_WAIT : S_SEND;
      S_WAIT: begin
        if (w_rise) begin
          w_next_state = S_RECV;
        end else if (r_cnt == LP_TMO_LAST) begin
          w_next_state = S_FIN;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RECV: w_next_state = (r_cnt == 16'd7) ? S_FIN : S_RECV;
      S_FIN:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so registered outputs line up with it
  always_comb begin
    w_busy_nx   = (w_next_state != S_IDLE);
    w_enable_nx = (w_next_state == S_SEND);
    w_done_nx   = (w_next_state == S_FIN);
    w_err_nx    = (r_state == S_WAIT) && (w_next_state == S_FIN);
    if ((r_state == S_RECV) && (w_next_state == S_FIN)) begin
      w_result_nx = {i_data_out, r_rx[63:8]};
    end else begin
      w_result_nx = o_result;
    end
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_busy   <= 1'b0;
      o_enable <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_result <= 64'd0;
    end else begin
      o_busy   <= w_busy_nx;
      o_enable <= w_enable_nx;
      o_done   <= w_done_nx;
      o_err    <= w_err_nx;
      o_result <= w_result_nx;
    end
  end

endmodule

// File: doc/fp_mul_host.md
FP_MUL_HOST -- requirements
Module: fp_mul_host

Interface
REQ-001 Parameter: TIMEOUT, 1023, max cycles WAIT_RDY waits for a READY rising edge before aborting (legal 2..65535).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request one multiply; sampled only in IDLE.
REQ-005 OP_A  input  64  IEEE-754 double operand A; latched on the accepting edge.
REQ-006 OP_B  input  64  IEEE-754 double operand B; latched on the accepting edge.
REQ-007 BUSY  output  1  high whenever state is not IDLE.
REQ-008 DONE  output  1  one-cycle completion pulse.
REQ-009 ERR  output  1  qualifies DONE; 1 means timeout abort.
REQ-010 RESULT  output  64  last successfully received product.
REQ-011 ENABLE  output  1  link strobe to multiplier; high while DATA_IN carries a valid byte.
REQ-012 DATA_IN  output  8  link byte to multiplier.
REQ-013 DATA_OUT  input  8  link byte from multiplier.
REQ-014 READY  input  1  multiplier result strobe; rising edge marks result byte 0 on DATA_OUT.

Function
REQ-015 The block SHALL implement states IDLE, SEND, WAIT_RDY, RECV, FIN; all link/host outputs registered.
REQ-016 In IDLE with START=1 the block SHALL latch OP_A/OP_B and enter SEND on the same edge.
REQ-017 SEND SHALL last exactly 16 cycles with ENABLE=1, DATA_IN = A[7:0], A[15:8] .. A[63:56], then B[7:0] .. B[63:56], one byte per cycle, LSB byte first, A before B.
REQ-018 The first SEND byte SHALL appear in the cycle after the accepting edge; no idle gap between bytes.
REQ-019 Outside SEND, ENABLE SHALL be 0 and DATA_IN SHALL be 8'h00.
REQ-020 A registered copy of READY SHALL be updated every cycle in every state; rising edge = READY=1 and copy=0.
REQ-021 READY edges occurring in IDLE, SEND, RECV or FIN SHALL be ignored.
REQ-022 In WAIT_RDY, on the edge where a READY rising edge is seen, DATA_OUT SHALL be captured as byte 0 and state SHALL go to RECV.
REQ-023 RECV SHALL capture DATA_OUT on each of the next 7 edges as bytes 1..7, irrespective of READY level, then enter FIN.
REQ-024 Received bytes assemble as {b7,b6,...,b0}; RESULT SHALL update only on entry to FIN after a full 8-byte capture.
REQ-025 FIN SHALL last one cycle: DONE=1, ERR=0, RESULT valid; next state IDLE.
REQ-026 WAIT_RDY SHALL count cycles from 0 at entry; if no READY edge seen by TIMEOUT cycles, state SHALL go to FIN with ERR=1 and RESULT unchanged.
REQ-027 A READY edge on the same edge the timeout expires SHALL take priority (capture proceeds).
REQ-028 START asserted while BUSY=1 SHALL be ignored and not queued; START in the FIN cycle is ignored.
REQ-029 Minimum transaction = 1 accept + 16 SEND + ≥1 WAIT_RDY + 7 RECV + 1 FIN cycles; back-to-back START accepted the cycle after FIN.
REQ-030 ERR SHALL be 0 whenever DONE=0.

Reset
REQ-031 RESET=1 at any edge SHALL force IDLE, ENABLE=0, DATA_IN=8'h00, BUSY=0, DONE=0, ERR=0, RESULT=64'h0, timeout counter=0, READY copy=0.
REQ-032 Reset mid-transaction (any state) SHALL abort with no DONE pulse and take effect at the next edge; RESET overrides START on the same edge.

Verification
REQ-033 OP_A=3FF0000000000000, OP_B=4000000000000000, responder raises READY 3 cycles after ENABLE falls and returns 4000000000000000 -> DATA_IN = 00x6,F0,3F,00x7,40; RESULT=4000000000000000, DONE one cycle, ERR=0.
REQ-034 TIMEOUT=20, READY held 0 -> DONE=1, ERR=1 exactly 20 cycles after WAIT_RDY entry; RESULT keeps prior value; BUSY drops next cycle.
REQ-035 RESET asserted after 5th SEND byte -> ENABLE=0, BUSY=0 next cycle, no DONE; subsequent START completes normally.
REQ-036 START held high continuously for 3 transactions with differing operands -> each accepted only in IDLE, 3 DONE pulses, no overlap in ENABLE bursts.
REQ-037 READY pulsed during SEND, then real READY rise in WAIT_RDY with bytes 11..88 -> SEND glitch ignored; RESULT=8877665544332211.
